natalius_imem_loader: RTL
=========================

// Module: natalius_imem_loader
// PURPOSE
//  Boot/programming controller for the Natalius instruction memory. Takes a
//  host byte stream (valid/ready), packs it into INST_W-bit words, writes them
//  through SRAM port 0 (csb0/web0/wmask0/addr0/din0/dout0) and can read each
//  word back to verify it. Holds the processor core in reset while loading and
//  releases it on success. Word width, address depth and read latency are
//  parameters.
// PARAMETERS
//  INST_W  16  instruction word width; must be a multiple of 8 (BPW = INST_W/8)
//  ADDR_W  11  SRAM word-address width
//  RD_LAT  1   cycles from a port-0 read command (csb0=0, web0=1) to valid dout0
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous reset, active low
//  load_start in   1         one-cycle pulse: start a load (ignored while busy)
//  load_base  in   ADDR_W    first word address, sampled on load_start
//  load_len   in   ADDR_W+1  word count, sampled on load_start (0..2^ADDR_W)
//  verify     in   1         sampled on load_start; 1 = read back each word
//  abort      in   1         synchronous abort to IDLE
//  s_valid    in   1         host byte valid
//  s_ready    out  1         loader accepts a byte this cycle
//  s_data     in   8         host byte
//  csb0       out  1         SRAM port-0 chip select, active low
//  web0       out  1         SRAM port-0 write enable, active low
//  wmask0     out  BPW       byte write mask
//  addr0      out  ADDR_W    SRAM port-0 address
//  din0       out  INST_W    SRAM port-0 write data
//  dout0      in   INST_W    SRAM port-0 read data
//  core_rst   out  1         active-high reset to the processor core
//  busy       out  1         load in progress
//  done       out  1         sticky: last load completed
//  err        out  1         sticky: verify mismatch in last load
//  err_addr   out  ADDR_W    address of the first mismatch
// BEHAVIOUR
//  Reset: state IDLE; s_ready=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0,
//   core_rst=1, busy=0, done=0, err=0, err_addr=0.
//  States: IDLE, COLLECT, WRITE, RDCMD, RDWAIT, CHECK.
//  IDLE: on load_start, latch base/len/verify and clear done, err and err_addr.
//   core_rst is set to 1. If len=0, set done=1, release core_rst and stay in
//   IDLE. Otherwise go to COLLECT with busy=1.
//  COLLECT: s_ready=1. Each s_valid&s_ready byte k (0..BPW-1) goes to
//   din0[8k+7:8k] (little-endian). After byte BPW-1, go to WRITE.
//  WRITE: one cycle with csb0=0, web0=0, wmask0=all 1s, addr0=base+i.
//   Then go to RDCMD if verify=1, else to the next word.
//  RDCMD: one cycle with csb0=0, web0=1 and the same addr0.
//   Then RDWAIT for RD_LAT-1 cycles (0 if RD_LAT=1), then CHECK.
//  CHECK: compare dout0 with din0. On mismatch with err=0, set err=1 and
//   latch err_addr. The load continues regardless.
//  Next word: i++. If i==len, go to IDLE with done=1, busy=0, and
//   core_rst=0 if err=0. Otherwise go to COLLECT.
//  csb0 is high in every cycle other than WRITE/RDCMD; s_ready=0 outside COLLECT.
//  Address arithmetic is modulo 2^ADDR_W: base+i wraps past 2^ADDR_W-1 to 0.
//  len=2^ADDR_W fills the whole memory.
//  Throughput: BPW+1 cycles/word without verify; BPW+2+RD_LAT with verify.
//  abort, any state: go to IDLE; busy=0, done=0, core_rst stays 1, csb0=1.
//   A partial byte group is discarded. abort has priority over load_start.
//  load_start while busy is ignored. A failed load keeps core_rst=1.
//  Asynchronous reset mid-load returns to the reset values immediately.
// TESTING
//  1 INST_W=16, base=0, len=3, verify=0, bytes 34 12 78 56 BC 9A ->
//    writes 0x1234@0, 0x5678@1, 0x9ABC@2; done=1, core_rst=0.
//  2 Same load with verify=1 and the SRAM model corrupting word 1 ->
//    err=1, err_addr=1, done=1, core_rst=1; words 0 and 2 still written.
//  3 base=0x7FE, len=4 -> writes go to addresses 0x7FE, 0x7FF, 0x000, 0x001.
//  4 len=0 -> done=1 and core_rst=0 in the cycle after load_start; no csb0 low.
//  5 abort after 1 byte of word 2 -> IDLE, done=0, core_rst=1, no write of
//    word 2; a new load then runs normally.
//  6 s_valid toggled at random with RD_LAT=2 -> no byte lost or duplicated;
//    load_start pulsed mid-load is ignored; rst low mid-WRITE gives csb0=1 at once.

Source files
------------

// File: rtl/natalius_imem_loader.sv
// Boot loader for the Natalius instruction SRAM: packs a host byte stream into
// words, writes them through port 0, optionally reads each back, then releases the core.
module natalius_imem_loader #(
   parameter int INST_W = 16,
   parameter int ADDR_W = 11,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [ADDR_W-1:0]     load_base,
   input  logic [ADDR_W:0]       load_len,
   input  logic                  verify,
   input  logic                  abort,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_data,
   output logic                  csb0,
   output logic                  web0,
   output logic [INST_W/8-1:0]   wmask0,
   output logic [ADDR_W-1:0]     addr0,
   output logic [INST_W-1:0]     din0,
   input  logic [INST_W-1:0]     dout0,
   output logic                  core_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_W-1:0]     err_addr
);
   localparam int BPW    = INST_W / 8;
   localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_WRITE, S_RDCMD, S_RDWAIT, S_CHECK
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_len;
   logic [ADDR_W:0]     r_idx;
   logic                r_verify;
   logic [BCNT_W-1:0]   r_bcnt;
   logic [WAIT_W-1:0]   r_wait;

   logic                w_accept;
   logic                w_mismatch;
   logic                w_word_end;
   logic                w_last_word;
   logic                w_err_now;

   assign w_accept    = s_valid & s_ready;
   assign w_mismatch  = (dout0 != din0);
   assign w_word_end  = ((r_state == S_WRITE) && !r_verify) || (r_state == S_CHECK);
   assign w_last_word = ((r_idx + (ADDR_W+1)'(1)) == r_len);
   // The last word's own mismatch must already count when deciding on core release.
   assign w_err_now   = err | ((r_state == S_CHECK) & w_mismatch);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_len    <= '0;
         r_idx    <= '0;
         r_verify <= 1'b0;
         r_bcnt   <= '0;
         r_wait   <= '0;
         s_ready  <= 1'b0;
         csb0     <= 1'b1;
         web0     <= 1'b1;
         wmask0   <= '0;
         addr0    <= '0;
         din0     <= '0;
         core_rst <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_addr <= '0;
      end else if (abort) begin
         r_state  <= S_IDLE;
         s_ready  <= 1'b0;
         csb0     <= 1'b1;
         web0     <= 1'b1;
         wmask0   <= '0;
         core_rst <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  r_base   <= load_base;
                  r_len    <= load_len;
                  r_verify <= verify;
                  r_idx    <= '0;
                  r_bcnt   <= '0;
                  err      <= 1'b0;
                  err_addr <= '0;
                  if (load_len == '0) begin
                     done     <= 1'b1;
                     core_rst <= 1'b0;
                  end else begin
                     done     <= 1'b0;
                     core_rst <= 1'b1;
                     busy     <= 1'b1;
                     s_ready  <= 1'b1;
                     r_state  <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  for (int b = 0; b < BPW; b++) begin
                     if (r_bcnt == BCNT_W'(b)) din0[8*b +: 8] <= s_data;
                  end
                  if (r_bcnt == LAST_BYTE) begin
                     s_ready <= 1'b0;
                     csb0    <= 1'b0;
                     web0    <= 1'b0;
                     wmask0  <= '1;
                     addr0   <= r_base + r_idx[ADDR_W-1:0];
                     r_state <= S_WRITE;
                  end else begin
                     r_bcnt  <= r_bcnt + BCNT_W'(1);
                  end
               end
            end
            S_WRITE: begin
               web0   <= 1'b1;
               wmask0 <= '0;
               csb0   <= ~r_verify;
               if (r_verify) r_state <= S_RDCMD;
            end
            S_RDCMD: begin
               csb0 <= 1'b1;
               if (RD_LAT > 1) begin
                  r_wait  <= WAIT_INIT;
                  r_state <= S_RDWAIT;
               end else begin
                  r_state <= S_CHECK;
               end
            end
            S_RDWAIT: begin
               if (r_wait == '0) r_state <= S_CHECK;
               else              r_wait  <= r_wait - WAIT_W'(1);
            end
            S_CHECK: begin
               if (w_mismatch && !err) begin
                  err      <= 1'b1;
                  err_addr <= addr0;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_word_end) begin
            r_idx <= r_idx + (ADDR_W+1)'(1);
            if (w_last_word) begin
               r_state  <= S_IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               core_rst <= w_err_now;
            end else begin
               r_bcnt   <= '0;
               s_ready  <= 1'b1;
               r_state  <= S_COLLECT;
            end
         end
      end
   end
endmodule
